// File: rtl/skew_feeder_if.sv
// Bundle of the tile-request, input-FIFO and array-row signals around skew_feeder.
// The master side drives requests and FIFO state; the slave side is the feeder itself.
interface skew_feeder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int LANES      = 16,
    parameter int LEN_W      = 8
);
    logic                        start;
    logic [LEN_W-1:0]            len;
    logic [LANES-1:0]            fifo_empty;
    logic [DATA_WIDTH*LANES-1:0] fifo_dout;
    logic [LANES-1:0]            fifo_rd_en;
    logic [DATA_WIDTH*LANES-1:0] row_data;
    logic [LANES-1:0]            row_valid;
    logic                        busy;
    logic                        done;

    modport master (
        output start, len, fifo_empty, fifo_dout,
        input  fifo_rd_en, row_data, row_valid, busy, done
    );

    modport slave (
        input  start, len, fifo_empty, fifo_dout,
        output fifo_rd_en, row_data, row_valid, busy, done
    );
endinterface

// File: rtl/skew_feeder.sv
// Pops LANES input FIFOs in lock-step and delays lane i by i cycles so that
// each tile vector enters the systolic array as a diagonal wavefront.
module skew_feeder #(
    parameter int DATA_WIDTH = 64,
    parameter int LANES      = 16,
    parameter int LEN_W      = 8
) (
    input logic          clk,
    input logic          rst,
    skew_feeder_if.slave bus
);
    localparam int DRAIN_W = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [LEN_W-1:0]            pop_cnt_q, pop_cnt_d;
    logic [DRAIN_W-1:0]          drain_cnt_q, drain_cnt_d;
    logic                        done_q, done_d;
    logic                        pop;
    logic [LANES-1:0]            vld_q;
    logic [DATA_WIDTH*LANES-1:0] row_data_w;

    always_comb begin
        state_d     = state_q;
        pop_cnt_d   = pop_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        pop_cnt_d = bus.len;
                        state_d   = FEED;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FEED: begin
                // A single empty lane stalls every lane so the wavefront stays aligned.
                if (bus.fifo_empty == '0 && pop_cnt_q != '0) begin
                    pop       = 1'b1;
                    pop_cnt_d = pop_cnt_q - LEN_W'(1);
                    if (pop_cnt_q == LEN_W'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(LANES - 1)) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pop_cnt_q   <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            pop_cnt_q   <= pop_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            vld_q[0]    <= pop;
            for (int i = 1; i < LANES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Lane 0 uses the FIFO read data directly; it lines up with the first valid stage.
    assign row_data_w[DATA_WIDTH-1:0] = vld_q[0] ? bus.fifo_dout[DATA_WIDTH-1:0] : '0;

    for (genvar g = 1; g < LANES; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] sr_q [g];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < g; k++) begin
                    sr_q[k] <= '0;
                end
            end else begin
                sr_q[0] <= bus.fifo_dout[DATA_WIDTH*g +: DATA_WIDTH];
                for (int k = 1; k < g; k++) begin
                    sr_q[k] <= sr_q[k-1];
                end
            end
        end

        assign row_data_w[DATA_WIDTH*g +: DATA_WIDTH] = vld_q[g] ? sr_q[g-1] : '0;
    end

    assign bus.fifo_rd_en = {LANES{pop}};
    assign bus.row_data   = row_data_w;
    assign bus.row_valid  = vld_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of one lane word.
REQ-002 SHALL have parameter LANES, default 16: number of FIFO lanes and array rows.
REQ-003 SHALL have parameter LEN_W, default 8: width of the vector-count input.
REQ-004 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1: one-cycle request to feed a tile; sampled only in IDLE.
REQ-007 SHALL have port len  input  LEN_W: number of vectors in the tile; captured with start.
REQ-008 SHALL have port fifo_empty  input  LANES: per-lane empty flags from the input FIFOs.
REQ-009 SHALL have port fifo_dout  input  DATA_WIDTH*LANES: per-lane FIFO read data; lane i at bits [DATA_WIDTH*i +: DATA_WIDTH]; valid the cycle after rd_en.
REQ-010 SHALL have port fifo_rd_en  output  LANES: per-lane FIFO pop strobes.
REQ-011 SHALL have port row_data  output  DATA_WIDTH*LANES: skewed data to array row inputs, same lane packing.
REQ-012 SHALL have port row_valid  output  LANES: per-row data-valid qualifiers.
REQ-013 SHALL have port busy  output  1: high in FEED and DRAIN.
REQ-014 SHALL have port done  output  1: one-cycle pulse at tile completion.

Function
REQ-015 SHALL implement FSM IDLE -> FEED -> DRAIN -> IDLE.
REQ-016 IDLE: start=1 with len>0 SHALL capture len into a pop counter and enter FEED next cycle; start=1 with len=0 SHALL pulse done next cycle and stay IDLE.
REQ-017 start in FEED or DRAIN SHALL be ignored.
REQ-018 FEED: in a cycle where all fifo_empty bits are 0, SHALL assert all LANES fifo_rd_en bits together (lock-step pop) and decrement the counter.
REQ-019 FEED: if any fifo_empty bit is 1, SHALL assert no fifo_rd_en bit that cycle (bubble); no partial pops ever.
REQ-020 fifo_rd_en SHALL be combinational from state, counter and fifo_empty, and SHALL be 0 outside FEED.
REQ-021 On the pop that brings the counter to 0, SHALL enter DRAIN next cycle.
REQ-022 A pop issued in cycle t SHALL set an internal valid bit v0 in cycle t+1, aligned with fifo_dout.
REQ-023 Lane i SHALL delay fifo_dout lane i and v0 by exactly i register stages: row_data lane i and row_valid[i] for a pop at t appear in cycle t+1+i.
REQ-024 Lane 0 SHALL therefore pass fifo_dout lane 0 through with zero added delay.
REQ-025 Bubbles SHALL propagate through the skew chain as valid=0, preserving diagonal alignment.
REQ-026 row_data lane i SHALL be driven to all-zero whenever row_valid[i]=0.
REQ-027 DRAIN SHALL count LANES cycles after the last pop, then pulse done for one cycle and return to IDLE in the same cycle.
REQ-028 For last pop at cycle t, row_valid[LANES-1] SHALL be high in t+LANES, done SHALL be high in t+LANES+1, and busy SHALL be low from t+LANES+1.
REQ-029 A new start SHALL be accepted in the cycle after done.
REQ-030 Total fifo_rd_en pulses per lane per tile SHALL equal len exactly.

Reset
REQ-031 rst=1 SHALL, asynchronously and at any time including mid-FEED or mid-DRAIN, force IDLE, clear the counter and all skew registers and valid bits, and force fifo_rd_en=0, row_valid=0, row_data=0, busy=0 and done=0.
REQ-032 After rst falls, the block SHALL require a fresh start; it SHALL NOT resume the aborted tile.

Verification
REQ-033 Set all FIFOs non-empty, start with len=4 at cycle 0 -> fifo_rd_en=16'hFFFF in cycles 1-4, row_valid[0] in cycles 2-5, row_valid[15] in cycles 17-20, done in cycle 21.
REQ-034 Hold fifo_empty[7]=1 for cycles 2-3 of a len=3 tile -> fifo_rd_en=0 in those cycles, 3 pops total, and every lane shows an identical valid pattern shifted by i.
REQ-035 Lane i data = {lane index, vector index} -> each row_data lane i carries the correct tag on the skewed cycle, and invalid cycles read zero.
REQ-036 Start with len=0 -> done in the next cycle, no fifo_rd_en, busy stays 0.
REQ-037 Pulse start in FEED and in DRAIN -> no effect; pop count equals the original len.
REQ-038 Assert rst during DRAIN -> all outputs are 0 immediately, no done follows, and a following start with len=2 completes normally.
